// File: rtl/fsm_defl_seq.sv
// State encoding and output decode shared by the deflation sequencer.
package fsm_defl_seq;

  typedef enum logic [3:0] {
    IDLE_DS,
    LOAD_INIT_DS,
    CLR_PI_DS,
    RUN_PI_DS,
    STORE_DS,
    CLR_UP_DS,
    RUN_UP_DS,
    LOAD_COV_DS,
    DONE_DS,
    ERR_DS
  } state_defl_seq;

  typedef struct packed {
    logic pi_clr;
    logic pi_start;
    logic up_clr;
    logic up_start;
    logic cov_sel;
    logic cov_load;
    logic eig_we;
    logic busy;
    logic f;
    logic err;
  } ctrl_out_t;

  // Moore output decode for one state.
  function automatic ctrl_out_t decode(input state_defl_seq s);
    ctrl_out_t o;
    o = '0;
    case (s)
      LOAD_INIT_DS: begin o.cov_load = 1'b1; o.busy = 1'b1; end
      CLR_PI_DS:    begin o.pi_clr = 1'b1;   o.busy = 1'b1; end
      RUN_PI_DS:    begin o.pi_start = 1'b1; o.busy = 1'b1; end
      STORE_DS:     begin o.eig_we = 1'b1;   o.busy = 1'b1; end
      CLR_UP_DS:    begin o.up_clr = 1'b1;   o.busy = 1'b1; end
      RUN_UP_DS:    begin o.up_start = 1'b1; o.busy = 1'b1; end
      LOAD_COV_DS:  begin o.cov_load = 1'b1; o.cov_sel = 1'b1; o.busy = 1'b1; end
      DONE_DS:      o.f = 1'b1;
      ERR_DS:       o.err = 1'b1;
      default:      o = '0;
    endcase
    return o;
  endfunction

  function automatic logic is_run(input state_defl_seq s);
    return (s == RUN_PI_DS) || (s == RUN_UP_DS);
  endfunction

endpackage

// File: rtl/defl_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th enabled cycle is reached.
module defl_watchdog #(
  parameter int unsigned LIMIT = 4096,
  localparam int unsigned W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired_c = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/deflation_sequencer.sv
// Deflation sequencer: per component runs power iteration, stores the eigenpair,
// then deflates the covariance. Macro DEFL_TIMEOUT_EN adds a wait-state watchdog.
module deflation_sequencer
  import fsm_defl_seq::*;
#(
  parameter int unsigned MAX_COMP = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned NUM_W = 8,
  localparam int unsigned IDX_W = (MAX_COMP > 1) ? $clog2(MAX_COMP) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_COMP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_comp,
  input  logic             pi_done,
  input  logic             up_done,
  output logic             pi_clr,
  output logic             pi_start,
  output logic             up_clr,
  output logic             up_start,
  output logic             cov_sel,
  output logic             cov_load,
  output logic             eig_we,
  output logic [IDX_W-1:0] comp_idx,
  output logic             busy,
  output logic             f,
  output logic             err
);

  state_defl_seq    state, state_next;
  logic [IDX_W-1:0] comp_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic [CNT_W-1:0] req_cnt_c;
  logic             last_c;
  logic             wd_expired_c;
  ctrl_out_t        ctrl_q;

  // Requested component count clamped to MAX_COMP.
  always_comb begin
    req_cnt_c = CNT_W'(num_comp);
    if (32'(num_comp) > MAX_COMP) begin
      req_cnt_c = CNT_W'(MAX_COMP);
    end
  end

  assign last_c = (32'(comp_idx) + 32'd1) == 32'(count_q);

`ifdef DEFL_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  // Clear on the edge that enters a run state so each wait starts from zero.
  assign wd_clear  = is_run(state_next) && !is_run(state);
  assign wd_enable = is_run(state);

  defl_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .expired_c(wd_expired_c)
  );
`else
  // No watchdog in this build; the parameter stays for a uniform interface.
  assign wd_expired_c = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE_DS;
      comp_idx <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      state    <= state_next;
      comp_idx <= comp_next;
      count_q  <= count_next;
      ctrl_q   <= decode(state_next);
    end
  end

  always_comb begin
    state_next = state;
    comp_next  = comp_idx;
    count_next = count_q;
    case (state)
      IDLE_DS, DONE_DS: begin
        if (start) begin
          if (num_comp == '0) begin
            state_next = DONE_DS;
          end else begin
            state_next = LOAD_INIT_DS;
            count_next = req_cnt_c;
            comp_next  = '0;
          end
        end
      end
      LOAD_INIT_DS: state_next = CLR_PI_DS;
      CLR_PI_DS:    state_next = RUN_PI_DS;
      RUN_PI_DS: begin
        if (pi_done) begin
          state_next = STORE_DS;
        end else if (wd_expired_c) begin
          state_next = ERR_DS;
        end
      end
      STORE_DS:     state_next = last_c ? DONE_DS : CLR_UP_DS;
      CLR_UP_DS:    state_next = RUN_UP_DS;
      RUN_UP_DS: begin
        if (up_done) begin
          state_next = LOAD_COV_DS;
        end else if (wd_expired_c) begin
          state_next = ERR_DS;
        end
      end
      LOAD_COV_DS: begin
        state_next = CLR_PI_DS;
        if (32'(comp_idx) < (MAX_COMP - 1)) begin
          comp_next = comp_idx + IDX_W'(1);
        end
      end
      ERR_DS:       state_next = ERR_DS;
      default:      state_next = IDLE_DS;
    endcase
  end

  assign pi_clr   = ctrl_q.pi_clr;
  assign pi_start = ctrl_q.pi_start;
  assign up_clr   = ctrl_q.up_clr;
  assign up_start = ctrl_q.up_start;
  assign cov_sel  = ctrl_q.cov_sel;
  assign cov_load = ctrl_q.cov_load;
  assign eig_we   = ctrl_q.eig_we;
  assign busy     = ctrl_q.busy;
  assign f        = ctrl_q.f;
  assign err      = ctrl_q.err;

endmodule

// File: tb/tb_deflation_sequencer.sv
// Scoreboard bench for deflation_sequencer with responder models of the
// power-iteration and covariance-update units.
module tb_deflation_sequencer;

  localparam int unsigned MAXC = 8;
  localparam int unsigned TO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_comp = '0;
  logic       pi_done = 1'b0;
  logic       up_done = 1'b0;
  logic       pi_clr, pi_start, up_clr, up_start, cov_sel, cov_load, eig_we;
  logic [2:0] comp_idx;
  logic       busy, f, err;

  deflation_sequencer #(
    .MAX_COMP(MAXC), .TIMEOUT_CYCLES(TO), .NUM_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_comp(num_comp),
    .pi_done(pi_done), .up_done(up_done),
    .pi_clr(pi_clr), .pi_start(pi_start), .up_clr(up_clr), .up_start(up_start),
    .cov_sel(cov_sel), .cov_load(cov_load), .eig_we(eig_we), .comp_idx(comp_idx),
    .busy(busy), .f(f), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Expected strobe events: kind*100 + sel*10 + idx (1 = store, 2 = cov load, 3 = done)
  int  sbq[$];
  bit  in_done = 1'b0;

  function automatic int ev(input int kind, input int sel, input int idx);
    return kind * 100 + sel * 10 + idx;
  endfunction

  task automatic model_run(input int n);
    int ne;
    ne = (n > int'(MAXC)) ? int'(MAXC) : n;
    if (n == 0) begin
      if (!in_done) sbq.push_back(ev(3, 0, 0));
    end else begin
      sbq.push_back(ev(2, 0, 0));
      for (int i = 0; i < ne; i++) begin
        sbq.push_back(ev(1, 0, i));
        if (i < ne - 1) sbq.push_back(ev(2, 1, i));
      end
      sbq.push_back(ev(3, 0, 0));
    end
    in_done = 1'b1;
  endtask

  int eig_cnt = 0, max_idx = 0, covsel1_cnt = 0, pi_clr_cnt = 0, cov_load_cnt = 0;
  bit f_prev = 1'b0;

  task automatic clr_stats();
    eig_cnt = 0; max_idx = 0; covsel1_cnt = 0; pi_clr_cnt = 0; cov_load_cnt = 0;
  endtask

  task automatic pop_chk(input int got);
    if (sbq.size() == 0) chk("sb_extra_event", got, 0);
    else chk("sb_event", got, sbq.pop_front());
  endtask

  // Monitor: compares every strobe the DUT presents against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (eig_we) begin
        eig_cnt++;
        if (int'(comp_idx) > max_idx) max_idx = int'(comp_idx);
        pop_chk(ev(1, 0, int'(comp_idx)));
      end
      if (cov_load) begin
        cov_load_cnt++;
        if (cov_sel) covsel1_cnt++;
        pop_chk(ev(2, int'(cov_sel), int'(comp_idx)));
      end
      if (f && !f_prev) pop_chk(ev(3, 0, 0));
      if (pi_clr) pi_clr_cnt++;
    end
    f_prev = f;
  end

  // Unit responders: sticky done flags, cleared by the clear strobe.
  int   pi_lat = 1, up_lat = 1, pi_cnt = 0, up_cnt = 0;
  bit   pi_hold = 1'b0;
  logic pi_nxt, up_nxt;

  initial forever begin
    @(negedge clk);
    pi_nxt = pi_done;
    up_nxt = up_done;
    if (!rst) begin
      pi_nxt = 1'b0; pi_cnt = 0; up_nxt = 1'b0; up_cnt = 0;
    end else begin
      if (pi_hold) pi_nxt = 1'b1;
      else if (pi_clr) begin pi_nxt = 1'b0; pi_cnt = 0; end
      else if (pi_start && !pi_done) begin
        pi_cnt++;
        if (pi_cnt >= pi_lat) pi_nxt = 1'b1;
      end
      if (up_clr) begin up_nxt = 1'b0; up_cnt = 0; end
      else if (up_start && !up_done) begin
        up_cnt++;
        if (up_cnt >= up_lat) up_nxt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    pi_done = pi_nxt;
    up_done = up_nxt;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle after start.
  task automatic do_start(input int n);
    num_comp = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while ((busy || sbq.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_now("run_complete");
  endtask

  function automatic int outs_vec();
    return int'({pi_clr, pi_start, up_clr, up_start, cov_sel, cov_load, eig_we, busy, f, err});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, runs, snap;
    cyc(2);
    chk("reset_outputs", outs_vec(), 0);
    chk("reset_comp_idx", int'(comp_idx), 0);
    rst = 1'b1;
    cyc(1);

    // Zero components from IDLE: done next cycle, nothing launched.
    clr_stats();
    model_run(0);
    do_start(0);
    chk("zero_f", int'(f), 1);
    chk("zero_busy", int'(busy), 0);
    cyc(2);
    chk("zero_pi_clr", pi_clr_cnt, 0);
    chk("zero_cov_load", cov_load_cnt, 0);

    // Cycle-level single-component run.
    pi_lat = 3;
    model_run(1);
    do_start(1);
    chk("c1_cov_load", int'(cov_load), 1);
    chk("c1_cov_sel", int'(cov_sel), 0);
    chk("c1_f_dropped", int'(f), 0);
    chk("c1_busy", int'(busy), 1);
    cyc(1);
    chk("c2_pi_clr", int'(pi_clr), 1);
    cyc(1);
    chk("c3_pi_start", int'(pi_start), 1);
    k = 0;
    while (!(pi_start && pi_done) && k < 50) begin cyc(1); k++; end
    if (k >= 50) fail_now("c_wait_pi_done");
    cyc(1);
    chk("c_store", int'(eig_we), 1);
    cyc(1);
    chk("c_f", int'(f), 1);
    chk("c_busy_low", int'(busy), 0);

    // Three components with fixed latencies.
    pi_lat = 10; up_lat = 5;
    clr_stats();
    model_run(3);
    do_start(3);
    wait_quiet(500);
    chk("n3_eig_cnt", eig_cnt, 3);
    chk("n3_covsel1_cnt", covsel1_cnt, 2);
    chk("n3_f", int'(f), 1);

    // Request above MAX_COMP is clamped.
    pi_lat = 2; up_lat = 2;
    clr_stats();
    model_run(12);
    do_start(12);
    wait_quiet(2000);
    chk("clamp_eig_cnt", eig_cnt, 8);
    chk("clamp_max_idx", max_idx, 7);

    // Stale pi_done held high through CLR_PI must not skip RUN_PI.
    pi_hold = 1'b1;
    model_run(1);
    do_start(1);
    cyc(1);
    chk("stale_clr_pi", int'(pi_clr), 1);
    chk("stale_done_high", int'(pi_done), 1);
    chk("stale_no_store_clr", int'(eig_we), 0);
    cyc(1);
    chk("stale_run_pi", int'(pi_start), 1);
    chk("stale_no_store_run", int'(eig_we), 0);
    cyc(1);
    chk("stale_store", int'(eig_we), 1);
    wait_quiet(200);
    pi_hold = 1'b0;

    // Randomized runs against the scoreboard model.
    for (runs = 0; runs < 10; runs++) begin
      int n;
      n = int'($urandom_range(0, 12));
      pi_lat = int'($urandom_range(1, 12));
      up_lat = int'($urandom_range(1, 8));
      model_run(n);
      do_start(n);
      wait_quiet(3000);
      chk("rand_f", int'(f), 1);
    end

    // Reset during RUN_UP of component 1, then restart.
    pi_lat = 4; up_lat = 6;
    model_run(3);
    do_start(3);
    k = 0;
    while (!(up_start && comp_idx == 3'd1) && k < 200) begin cyc(1); k++; end
    if (k >= 200) fail_now("rst_wait_run_up");
    rst = 1'b0;
    #1;
    chk("midrst_outputs", outs_vec(), 0);
    chk("midrst_comp_idx", int'(comp_idx), 0);
    sbq.delete();
    in_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    clr_stats();
    model_run(2);
    do_start(2);
    chk("restart_idx", int'(comp_idx), 0);
    chk("restart_load", int'(cov_load), 1);
    wait_quiet(500);
    chk("restart_eig_cnt", eig_cnt, 2);

`ifdef DEFL_TIMEOUT_EN
    // Power iteration never completes: watchdog aborts after TO RUN_PI cycles.
    pi_lat = 1_000_000;
    model_run(2);
    do_start(2);
    k = 0; snap = 0;
    while (!err && k < 100) begin
      if (pi_start) snap++;
      cyc(1);
      k++;
    end
    chk("to_run_pi_cycles", snap, int'(TO));
    chk("to_err", int'(err), 1);
    chk("to_pi_start_low", int'(pi_start), 0);
    chk("to_busy_low", int'(busy), 0);
    chk("to_f_low", int'(f), 0);
    sbq.delete();
    snap = cov_load_cnt;
    do_start(1);
    cyc(3);
    chk("to_start_ignored_err", int'(err), 1);
    chk("to_start_ignored_load", cov_load_cnt, snap);
    chk("to_start_ignored_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    in_done = 1'b0;
    chk("to_err_cleared", int'(err), 0);
    pi_lat = 2;
`else
    chk("err_tied_low", int'(err), 0);
    snap = 0;
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
